// File: rtl/lifo_param.sv
// Parametrised LIFO stack with simultaneous push/pop, occupancy count,
// registered pop data with a valid strobe and sticky overflow/underflow flags.
module lifo_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             push,
    input  logic             pop,
    input  logic             ERR_CLR,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             DOUT_VALID,
    output logic [CW-1:0]    count,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic             OVF,
    output logic             UNF
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("lifo_param: DEPTH must be at least 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("lifo_param: AF_LEVEL must lie in 1..DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             dv_reg, dv_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             rd_en;
    logic             bypass;
    logic             empty_w, full_w;
    logic [AW-1:0]    wr_addr, top_addr;

    assign empty_w  = (count_reg == '0);
    assign full_w   = (count_reg == DEPTH_CNT);
    assign wr_addr  = AW'(count_reg);
    assign top_addr = AW'(count_reg - 1'b1);

    always_comb begin
        count_next = count_reg;
        dv_next    = 1'b0;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        rd_en      = 1'b0;
        bypass     = 1'b0;
        if (EN) begin
            if (ERR_CLR) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
            end
            // error sets come after the clear so a same-cycle error wins
            unique case ({push, pop})
                2'b10: begin
                    if (full_w) begin
                        ovf_next = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        count_next = count_reg + 1'b1;
                    end
                end
                2'b01: begin
                    if (empty_w) begin
                        unf_next = 1'b1;
                    end else begin
                        rd_en      = 1'b1;
                        dv_next    = 1'b1;
                        count_next = count_reg - 1'b1;
                    end
                end
                2'b11: begin
                    dv_next = 1'b1;
                    if (empty_w) begin
                        bypass = 1'b1;
                    end else begin
                        // swap the top: old value is read out, new value takes its slot
                        rd_en     = 1'b1;
                        mem_we    = 1'b1;
                        mem_waddr = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // storage is never reset, so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we && !Rst) begin
            mem[mem_waddr] <= dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            dout_reg <= '0;
        end else if (rd_en) begin
            dout_reg <= mem[top_addr];
        end else if (bypass) begin
            dout_reg <= dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            count_reg <= '0;
            dv_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            dv_reg    <= dv_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign dataOut     = dout_reg;
    assign DOUT_VALID  = dv_reg;
    assign count       = count_reg;
    assign EMPTY       = empty_w;
    assign FULL        = full_w;
    assign ALMOST_FULL = (count_reg >= AF_CNT);
    assign OVF         = ovf_reg;
    assign UNF         = unf_reg;

endmodule

// File: tb/tb_lifo_param.sv
// Directed bench for lifo_param (WIDTH=4, DEPTH=4, AF_LEVEL=3): pop data is
// checked by a queue-based monitor, status outputs by the stimulus process.
module tb_lifo_param;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             Rst, EN, push, pop, ERR_CLR;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut;
    logic             DOUT_VALID;
    logic [CW-1:0]    count;
    logic             EMPTY, FULL, ALMOST_FULL, OVF, UNF;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [WIDTH-1:0] exp_q [$];

    lifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .Rst(Rst), .EN(EN), .push(push), .pop(pop), .ERR_CLR(ERR_CLR),
        .dataIn(dataIn), .dataOut(dataOut), .DOUT_VALID(DOUT_VALID), .count(count),
        .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .OVF(OVF), .UNF(UNF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock of stimulus; if a pop result is due, queue the expected data first.
    task automatic tick(input logic en, input logic ps, input logic pp, input logic clr,
                        input logic [WIDTH-1:0] d, input logic want, input logic [WIDTH-1:0] e);
        EN = en; push = ps; pop = pp; ERR_CLR = clr; dataIn = d;
        if (want) exp_q.push_back(e);
        @(posedge clk);
        #1;
        $display("t=%0t en=%b push=%b pop=%b clr=%b din=%h -> count=%0d dout=%h vld=%b ovf=%b unf=%b",
                 $time, en, ps, pp, clr, d, count, dataOut, DOUT_VALID, OVF, UNF);
    endtask

    // Monitor: every valid pop result must match the next queued expectation.
    always @(negedge clk) begin
        if (DOUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_valid: got dout=%h expected no valid", dataOut);
            end else begin
                chk("pop_data", 32'(dataOut), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        Rst = 1'b1; EN = 1'b0; push = 1'b0; pop = 1'b0; ERR_CLR = 1'b0; dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        Rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_full", 32'(FULL), 0);
        chk("rst_af", 32'(ALMOST_FULL), 0);
        chk("rst_dout", 32'(dataOut), 0);
        chk("rst_valid", 32'(DOUT_VALID), 0);
        chk("rst_ovf", 32'(OVF), 0);
        chk("rst_unf", 32'(UNF), 0);

        // 1: fill
        tick(1, 1, 0, 0, 4'h0, 0, 0);
        chk("s1_count1", 32'(count), 1); chk("s1_empty1", 32'(EMPTY), 0); chk("s1_af1", 32'(ALMOST_FULL), 0);
        tick(1, 1, 0, 0, 4'h2, 0, 0);
        chk("s1_count2", 32'(count), 2); chk("s1_af2", 32'(ALMOST_FULL), 0);
        tick(1, 1, 0, 0, 4'h4, 0, 0);
        chk("s1_count3", 32'(count), 3); chk("s1_af3", 32'(ALMOST_FULL), 1); chk("s1_full3", 32'(FULL), 0);
        tick(1, 1, 0, 0, 4'h6, 0, 0);
        chk("s1_count4", 32'(count), 4); chk("s1_full4", 32'(FULL), 1);

        // 2: drain
        tick(1, 0, 1, 0, 4'h0, 1, 4'h6); chk("s2_count3", 32'(count), 3);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h4); chk("s2_count2", 32'(count), 2);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h2); chk("s2_count1", 32'(count), 1);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h0);
        chk("s2_count0", 32'(count), 0); chk("s2_empty", 32'(EMPTY), 1);

        // 3: overflow and clear
        tick(1, 1, 0, 0, 4'h0, 0, 0);
        tick(1, 1, 0, 0, 4'h2, 0, 0);
        tick(1, 1, 0, 0, 4'h4, 0, 0);
        tick(1, 1, 0, 0, 4'h6, 0, 0);
        tick(1, 1, 0, 0, 4'hA, 0, 0);
        chk("s3_ovf", 32'(OVF), 1); chk("s3_count", 32'(count), 4);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h6);
        chk("s3_count_pop", 32'(count), 3); chk("s3_ovf_hold", 32'(OVF), 1);
        tick(1, 0, 0, 1, 4'h0, 0, 0);
        chk("s3_ovf_clr", 32'(OVF), 0);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h4);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h2);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h0);

        // 4: underflow, then bypass on empty
        tick(1, 0, 1, 0, 4'h0, 0, 0);
        chk("s4_unf", 32'(UNF), 1); chk("s4_valid", 32'(DOUT_VALID), 0);
        chk("s4_dout_hold", 32'(dataOut), 0); chk("s4_count", 32'(count), 0);
        tick(1, 1, 1, 0, 4'h5, 1, 4'h5);
        chk("s4_byp_count", 32'(count), 0); chk("s4_byp_valid", 32'(DOUT_VALID), 1);
        chk("s4_unf_hold", 32'(UNF), 1);

        // 5: swap top with push+pop
        tick(1, 1, 0, 0, 4'h0, 0, 0);
        tick(1, 1, 0, 0, 4'h2, 0, 0);
        tick(1, 1, 1, 0, 4'h9, 1, 4'h2);
        chk("s5_swap_count", 32'(count), 2); chk("s5_ovf", 32'(OVF), 0);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h9);
        tick(1, 0, 1, 0, 4'h0, 1, 4'h0);
        chk("s5_count", 32'(count), 0);

        // 6: EN=0 holds everything, then reset with a push pending
        tick(1, 1, 0, 0, 4'h1, 0, 0);
        tick(1, 1, 0, 0, 4'h2, 0, 0);
        tick(1, 1, 0, 0, 4'h3, 0, 0);
        tick(1, 1, 1, 0, 4'h7, 1, 4'h3);
        tick(0, 1, 0, 1, 4'hF, 0, 0);
        chk("s6_en0_count_a", 32'(count), 3); chk("s6_en0_valid_a", 32'(DOUT_VALID), 0);
        tick(0, 0, 1, 1, 4'hF, 0, 0);
        chk("s6_en0_count_b", 32'(count), 3); chk("s6_en0_dout", 32'(dataOut), 3);
        tick(0, 1, 1, 0, 4'hF, 0, 0);
        chk("s6_en0_count_c", 32'(count), 3); chk("s6_en0_unf", 32'(UNF), 1);
        Rst = 1'b1;
        tick(1, 1, 0, 0, 4'hE, 0, 0);
        Rst = 1'b0;
        chk("s6_rst_count", 32'(count), 0); chk("s6_rst_empty", 32'(EMPTY), 1);
        chk("s6_rst_dout", 32'(dataOut), 0); chk("s6_rst_ovf", 32'(OVF), 0);
        chk("s6_rst_unf", 32'(UNF), 0);

        tick(1, 0, 0, 0, 4'h0, 0, 0);
        tick(1, 0, 0, 0, 4'h0, 0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lifo_param.md
Name: lifo_param

Overview:
Parametrised successor to the fixed 4-bit LIFO stack. It takes separate push and pop strobes, so both can happen in the same cycle, and its width, depth and almost-full level are parameters. It adds an occupancy count, a read-valid strobe and sticky overflow/underflow error flags. It sits between a producer and a consumer that need last-in-first-out buffering, for example context save/restore or backtracking.

Parameters:
WIDTH, 4, data width in bits (>=1)
DEPTH, 8, number of stack entries (>=2)
AF_LEVEL, DEPTH-1, ALMOST_FULL asserts when count >= AF_LEVEL (legal range 1..DEPTH)
CW, $clog2(DEPTH+1), count width (derived; do not override)

Ports:
clk  in  1  clock; all logic on rising edge
Rst  in  1  reset; synchronous, active-high
EN  in  1  global enable; when 0, push/pop/ERR_CLR are ignored and state holds
push  in  1  push request
pop  in  1  pop request
ERR_CLR  in  1  clears OVF/UNF
dataIn  in  WIDTH  push data
dataOut  out  WIDTH  registered pop data
DOUT_VALID  out  1  one-cycle pulse; dataOut updated by a pop
count  out  CW  current occupancy, 0..DEPTH
EMPTY  out  1  count==0
FULL  out  1  count==DEPTH
ALMOST_FULL  out  1  count>=AF_LEVEL
OVF  out  1  sticky: push attempted while full
UNF  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (Rst=1 at edge; overrides EN and all requests):
  - count=0, dataOut=0, DOUT_VALID=0, OVF=0, UNF=0.
  - Hence EMPTY=1, FULL=0, ALMOST_FULL=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data in one cycle.
- Storage: mem[0..DEPTH-1]; stack pointer sp=count; top of stack = mem[sp-1].
- EMPTY, FULL and ALMOST_FULL are combinational decodes of the count register. No extra latency.
- Pop latency is 1 cycle: the top entry appears on dataOut at the edge after the pop is sampled, and DOUT_VALID=1 for that cycle.
- dataOut holds its last value when no pop succeeds.
- Per-edge actions when EN=1 and Rst=0:
  - push only, not full: mem[sp]<=dataIn; count+1.
  - push only, full: no write; count unchanged; OVF<=1.
  - pop only, not empty: dataOut<=mem[sp-1]; DOUT_VALID<=1; count-1.
  - pop only, empty: dataOut held; DOUT_VALID<=0; UNF<=1.
  - push+pop, count>=1 (including full): dataOut<=mem[sp-1]; mem[sp-1]<=dataIn; DOUT_VALID<=1; count unchanged; no OVF/UNF.
  - push+pop, empty: bypass; dataOut<=dataIn; DOUT_VALID<=1; count stays 0; no UNF.
  - neither: DOUT_VALID<=0.
- ERR_CLR (EN=1) clears OVF and UNF. If a new error occurs in the same cycle, the set wins.
- EN=0: no memory write, count/dataOut/flags hold, DOUT_VALID<=0.
- count never wraps: it saturates at 0 and DEPTH through the ignore rules above.
- Elaboration must fail if DEPTH<2 or AF_LEVEL is outside 1..DEPTH.

Test Plan:
(Parameters for all scenarios: WIDTH=4, DEPTH=4, AF_LEVEL=3.)
1. Rst=1 for 2 edges, then EN=1 and push 0,2,4,6 on consecutive cycles -> count 1,2,3,4; ALMOST_FULL rises at count=3; FULL=1 after the 4th push; EMPTY=0 after the 1st push.
2. From full, pop 4 consecutive cycles -> dataOut 6,4,2,0 on the following edges, DOUT_VALID high 4 cycles, EMPTY=1 after the last pop, count=0.
3. Fill 0,2,4,6, then push 0xA -> OVF=1, count=4; then pop -> dataOut=6; then ERR_CLR -> OVF=0.
4. Empty, pop -> UNF=1, DOUT_VALID=0, dataOut unchanged. Then push+pop with dataIn=5 on the empty stack -> dataOut=5, DOUT_VALID=1, count=0, UNF remains set.
5. Stack holds 0,2 (top=2); push+pop with dataIn=9 -> dataOut=2, count=2; next pop -> dataOut=9; next pop -> dataOut=0.
6. Count=3 with EN=0 and push/pop toggling for 3 cycles -> no change. Then Rst=1 together with push=1 -> count=0, EMPTY=1, dataOut=0, OVF=UNF=0.
